multicycle_control_fsm: RTL



---
 rtl/multicycle_control_fsm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU.
// It steps each instruction through fetch, decode, execute, memory and
// write-back. It drives the shared memory strobes, the datapath muxes and
// the register enables.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state_q, state_d;

  // These write enables are built here and then gated by reset further down.
  logic pc_write_raw, pc_write_cond_raw, ir_write_raw, reg_write_raw, mem_write_raw;

  // State register. Reset returns to FETCH from any state, which abandons
  // any instruction that was part-way through.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every register reads pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic. OpCode/Funct matter only from DECODE onward.
  always_comb begin
    // NOTE: a default goes first so that no path through the case can infer a latch.
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = (Funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_SLTI, OP_SLTIU, OP_LUI:
                          state_d = S_I_EXEC;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_LW_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode. In I_EXEC and I_WB the ALU controls also depend on
  // the opcode, so the result stays stable while the register file writes.
  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    mem_write_raw     = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemtoReg  = 2'b00;
    RegDst    = 2'b00;
    ExtOp     = 1'b0;
    LuiOp     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 3'b000;
    PCSource  = 2'b00;
    IllegalOp = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead      = 1'b1;
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b01;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        // The branch target is computed early and lands in ALUOut.
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        case (OpCode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_JAL,
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_SLTI, OP_SLTIU, OP_LUI: IllegalOp = 1'b0;
          default:                   IllegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LW_WB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 2'b01;
      end
      S_MEM_WR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_R_WB: begin
        reg_write_raw = 1'b1;
        RegDst        = 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = 3'b001;
        pc_write_cond_raw = 1'b1;
        PCSource          = 2'b01;
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b10;
        if (OpCode == OP_JAL) begin
          // The PC already holds PC+4, which is the link address.
          reg_write_raw = 1'b1;
          RegDst        = 2'b10;
          MemtoReg      = 2'b10;
        end
      end
      S_JR: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b11;
      end
      S_I_EXEC, S_I_WB: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OpCode)
          OP_ANDI:  ALUOp = 3'b100;
          OP_ORI:   ALUOp = 3'b101;
          OP_SLTI:  begin ExtOp = 1'b1; ALUOp = 3'b011; end
          OP_SLTIU: begin ExtOp = 1'b1; ALUOp = 3'b110; end
          OP_LUI:   LuiOp = 1'b1;
          default:  ExtOp = 1'b1;
        endcase
        if (state_q == S_I_WB) reg_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is high, no architectural write can happen.
  assign PCWrite     = pc_write_raw      & ~reset;
  assign PCWriteCond = pc_write_cond_raw & ~reset;
  assign IRWrite     = ir_write_raw      & ~reset;
  assign RegWrite    = reg_write_raw     & ~reset;
  assign MemWrite    = mem_write_raw     & ~reset;
  assign State       = state_q;

endmodule
